// File: rtl/lab2_proc_mem_arbiter_pkg.sv
// lab2_proc_mem_arbiter_pkg: shared message types, source tags and priority enum for the imem/dmem arbiter
package lab2_proc_mem_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef enum logic {PRIO_IMEM = 1'b0, PRIO_DMEM = 1'b1} prio_t;

    localparam logic LAB2_PROC_MEM_ARB_SRC_IMEM = 1'b0;
    localparam logic LAB2_PROC_MEM_ARB_SRC_DMEM = 1'b1;
    localparam int   LAB2_PROC_MEM_ARB_TAG_BIT  = 7;

endpackage

// File: rtl/lab2_proc_mem_arbiter_rr.sv
// lab2_proc_RoundRobinArb2: two-input round-robin arbiter holding its own priority register
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : requests, bit 0 = imem, bit 1 = dmem
//   en         : a grant was accepted this cycle, so priority moves to the loser
//   grant[1:0] : one-hot (or zero) grant, combinational from req and priority
module lab2_proc_RoundRobinArb2
    import lab2_proc_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    prio_t r_prio;
    prio_t w_prio_next;

    always_ff @(posedge clk) begin
        if (reset) r_prio <= PRIO_IMEM;
        else       r_prio <= w_prio_next;
    end

    always_comb begin
        w_prio_next = r_prio;
        grant       = req;
        if (req == 2'b11) grant = (r_prio == PRIO_DMEM) ? 2'b10 : 2'b01;
        if (en) w_prio_next = grant[0] ? PRIO_DMEM : PRIO_IMEM;
    end

endmodule

// File: rtl/lab2_proc_mem_arbiter.sv
// lab2_proc_mem_arbiter: merges imem/dmem request streams onto one memory port and routes responses back by tag
//   clk, reset                       : clock and synchronous active-high reset
//   imemreq_* / dmemreq_*            : val/rdy request inputs from the processor ports
//   memreq_*                         : merged request to memory, opaque[7] carries the source tag
//   memresp_*                        : response from memory, steered by opaque[7]
//   imemresp_* / dmemresp_*          : per-port responses, opaque[7] cleared
//   num_imem_grants, num_dmem_grants,
//   num_conflicts                    : 32-bit statistics, present only with LAB2_PROC_MEM_ARB_STATS_EN defined
module lab2_proc_mem_arbiter
    import lab2_proc_mem_arbiter_pkg::*;
#(
    parameter int p_max_outstanding = 2
)(
    input  logic         clk,
    input  logic         reset,
    input  mem_req_4B_t  imemreq_msg,
    input  logic         imemreq_val,
    output logic         imemreq_rdy,
    input  mem_req_4B_t  dmemreq_msg,
    input  logic         dmemreq_val,
    output logic         dmemreq_rdy,
    output mem_req_4B_t  memreq_msg,
    output logic         memreq_val,
    input  logic         memreq_rdy,
    input  mem_resp_4B_t memresp_msg,
    input  logic         memresp_val,
    output logic         memresp_rdy,
    output mem_resp_4B_t imemresp_msg,
    output logic         imemresp_val,
    input  logic         imemresp_rdy,
    output mem_resp_4B_t dmemresp_msg,
    output logic         dmemresp_val,
    input  logic         dmemresp_rdy
`ifdef LAB2_PROC_MEM_ARB_STATS_EN
    ,
    output logic [31:0]  num_imem_grants,
    output logic [31:0]  num_dmem_grants,
    output logic [31:0]  num_conflicts
`endif
);

    localparam int             CW    = $clog2(p_max_outstanding + 1);
    localparam logic [CW-1:0]  C_MAX = CW'(p_max_outstanding);

    logic [CW-1:0] r_cnt_i, r_cnt_d, w_cnt_i_next, w_cnt_d_next;
    logic          w_elig_i, w_elig_d, w_fire, w_tag;
    logic          w_req_fire_i, w_req_fire_d, w_resp_fire_i, w_resp_fire_d;
    logic [1:0]    w_grant;
    mem_resp_4B_t  w_resp;

    // Eligibility is masked by reset so every val/rdy and fire is quiet while reset is high.
    assign w_elig_i = !reset && imemreq_val && (r_cnt_i < C_MAX);
    assign w_elig_d = !reset && dmemreq_val && (r_cnt_d < C_MAX);

    lab2_proc_RoundRobinArb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({w_elig_d, w_elig_i}),
        .en    (w_fire),
        .grant (w_grant)
    );

    assign memreq_val  = w_elig_i || w_elig_d;
    assign w_fire      = memreq_val && memreq_rdy;
    assign imemreq_rdy = w_grant[0] && memreq_rdy;
    assign dmemreq_rdy = w_grant[1] && memreq_rdy;

    always_comb begin
        memreq_msg = w_grant[1] ? dmemreq_msg : imemreq_msg;
        memreq_msg.opaque[LAB2_PROC_MEM_ARB_TAG_BIT] = w_grant[1] ? LAB2_PROC_MEM_ARB_SRC_DMEM
                                                                  : LAB2_PROC_MEM_ARB_SRC_IMEM;
    end

    assign w_tag = memresp_msg.opaque[LAB2_PROC_MEM_ARB_TAG_BIT];

    always_comb begin
        w_resp = memresp_msg;
        w_resp.opaque[LAB2_PROC_MEM_ARB_TAG_BIT] = 1'b0;
    end

    assign imemresp_msg = w_resp;
    assign dmemresp_msg = w_resp;
    assign imemresp_val = !reset && memresp_val && (w_tag == LAB2_PROC_MEM_ARB_SRC_IMEM);
    assign dmemresp_val = !reset && memresp_val && (w_tag == LAB2_PROC_MEM_ARB_SRC_DMEM);
    assign memresp_rdy  = !reset && ((w_tag == LAB2_PROC_MEM_ARB_SRC_DMEM) ? dmemresp_rdy : imemresp_rdy);

    assign w_req_fire_i  = imemreq_val && imemreq_rdy;
    assign w_req_fire_d  = dmemreq_val && dmemreq_rdy;
    assign w_resp_fire_i = imemresp_val && imemresp_rdy;
    assign w_resp_fire_d = dmemresp_val && dmemresp_rdy;

    // A stray response at count 0 leaves the counter at 0 rather than wrapping.
    always_comb begin
        w_cnt_i_next = (w_req_fire_i && !w_resp_fire_i) ? r_cnt_i + CW'(1)
                     : (w_resp_fire_i && !w_req_fire_i && r_cnt_i != '0) ? r_cnt_i - CW'(1)
                     : r_cnt_i;
        w_cnt_d_next = (w_req_fire_d && !w_resp_fire_d) ? r_cnt_d + CW'(1)
                     : (w_resp_fire_d && !w_req_fire_d && r_cnt_d != '0) ? r_cnt_d - CW'(1)
                     : r_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_i <= '0;
            r_cnt_d <= '0;
        end else begin
            r_cnt_i <= w_cnt_i_next;
            r_cnt_d <= w_cnt_d_next;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && ((w_resp_fire_i && r_cnt_i == '0) || (w_resp_fire_d && r_cnt_d == '0)))
            $error("lab2_proc_mem_arbiter: response for a port with no outstanding request");
    end
`endif

`ifdef LAB2_PROC_MEM_ARB_STATS_EN
    logic [31:0] r_num_i, r_num_d, r_num_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_i <= '0;
            r_num_d <= '0;
            r_num_c <= '0;
        end else begin
            if (w_fire && w_grant[0])           r_num_i <= r_num_i + 32'd1;
            if (w_fire && w_grant[1])           r_num_d <= r_num_d + 32'd1;
            if (w_fire && w_elig_i && w_elig_d) r_num_c <= r_num_c + 32'd1;
        end
    end

    assign num_imem_grants = r_num_i;
    assign num_dmem_grants = r_num_d;
    assign num_conflicts   = r_num_c;
`endif

endmodule
